// File: rtl/regfile_pkg.sv
// Shared defaults and state encoding for the multi-ported physical register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 6;
  localparam int N_WR_DEF   = 4;
  localparam int N_RD_DEF   = 12;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rfState_t;

endpackage

// File: rtl/phys_reg_file_mp_if.sv
// Bus bundle for phys_reg_file_mp: write/clear ports, read selects and registered read results.
interface phys_reg_file_mp_if #(
  parameter int DATA_W = regfile_pkg::DATA_W_DEF,
  parameter int ADDR_W = regfile_pkg::ADDR_W_DEF,
  parameter int N_WR   = regfile_pkg::N_WR_DEF,
  parameter int N_RD   = regfile_pkg::N_RD_DEF
);

  logic                     en;
  logic [N_WR-1:0]          writeEn;
  logic [N_WR*ADDR_W-1:0]   writeSelect;
  logic [N_WR*DATA_W-1:0]   writeData;
  logic [N_WR-1:0]          clearEn;
  logic [N_WR*ADDR_W-1:0]   clearSelect;
  logic [N_RD*ADDR_W-1:0]   readSelect;
  logic [N_RD*DATA_W-1:0]   readData;
  logic [N_RD-1:0]          readReady;
  logic                     initBusy;

  modport master (
    output en, writeEn, writeSelect, writeData, clearEn, clearSelect, readSelect,
    input  readData, readReady, initBusy
  );

  modport slave (
    input  en, writeEn, writeSelect, writeData, clearEn, clearSelect, readSelect,
    output readData, readReady, initBusy
  );

endinterface

// File: rtl/regfile_wr_merge.sv
// Per-read-port merge of same-cycle writes/clears onto array contents.
// Forwarding is active only when REGFILE_BYPASS_EN is defined; otherwise array contents pass through.
module regfile_wr_merge
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int N_WR   = N_WR_DEF
) (
  input  logic [ADDR_W-1:0]       readSel,
  input  logic [DATA_W-1:0]       arrData,
  input  logic                    arrReady,
  input  logic [N_WR-1:0]         writeEn,
  input  logic [N_WR*ADDR_W-1:0]  writeSelect,
  input  logic [N_WR*DATA_W-1:0]  writeData,
  input  logic [N_WR-1:0]         clearEn,
  input  logic [N_WR*ADDR_W-1:0]  clearSelect,
  output logic [DATA_W-1:0]       mergedData,
  output logic                    mergedReady
);

`ifdef REGFILE_BYPASS_EN
  // Ascending scan lets the highest-index write win; clears are applied last so they beat writes.
  always_comb begin
    mergedData  = arrData;
    mergedReady = arrReady;
    for (int i = 0; i < N_WR; i++) begin
      if (writeEn[i] && (writeSelect[i*ADDR_W +: ADDR_W] == readSel)) begin
        mergedData  = writeData[i*DATA_W +: DATA_W];
        mergedReady = 1'b1;
      end
    end
    for (int i = 0; i < N_WR; i++) begin
      if (clearEn[i] && (clearSelect[i*ADDR_W +: ADDR_W] == readSel)) begin
        mergedReady = 1'b0;
      end
    end
  end
`else
  assign mergedData  = arrData;
  assign mergedReady = arrReady;

  logic unusedBypassInputs;
  assign unusedBypassInputs = ^{readSel, writeEn, writeSelect, writeData, clearEn, clearSelect};
`endif

endmodule

// File: rtl/phys_reg_file_mp.sv
// Multi-ported physical register file with ready bits and a post-reset clear sequence.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module phys_reg_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int N_WR   = N_WR_DEF,
  parameter int N_RD   = N_RD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  phys_reg_file_mp_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  rfState_t          state, nextState;
  logic [ADDR_W-1:0] initCount, nextCount;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  readyBits;
  logic              isRun;
  logic [N_WR-1:0]   wrEnRun, clrEnRun;

  assign isRun        = (state == RUN);
  assign wrEnRun      = bus.writeEn & {N_WR{isRun}};
  assign clrEnRun     = bus.clearEn & {N_WR{isRun}};
  assign bus.initBusy = !isRun;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= INIT;
      initCount <= '0;
    end else begin
      state     <= nextState;
      initCount <= nextCount;
    end
  end

  always_comb begin
    nextState = state;
    nextCount = initCount;
    if (state == INIT) begin
      nextCount = initCount + 1'b1;
      if (initCount == '1) nextState = RUN;
    end
  end

  // NOTE: the storage array carries no reset; the INIT sweep clears it, which keeps it in plain RAM cells.
  always_ff @(posedge clk) begin
    if (!isRun) begin
      mem[initCount]       <= '0;
      readyBits[initCount] <= 1'b1;
    end else begin
      // NOTE: within one block the last non-blocking assignment to a location wins, so the
      // ascending loop gives the highest-index port priority and clears override writes.
      for (int i = 0; i < N_WR; i++) begin
        if (wrEnRun[i]) begin
          mem[bus.writeSelect[i*ADDR_W +: ADDR_W]]       <= bus.writeData[i*DATA_W +: DATA_W];
          readyBits[bus.writeSelect[i*ADDR_W +: ADDR_W]] <= 1'b1;
        end
      end
      for (int i = 0; i < N_WR; i++) begin
        if (clrEnRun[i]) readyBits[bus.clearSelect[i*ADDR_W +: ADDR_W]] <= 1'b0;
      end
    end
  end

  logic [DATA_W-1:0]      mergedData [N_RD];
  logic [N_RD-1:0]        mergedReady;
  logic [N_RD*DATA_W-1:0] rdDataQ;
  logic [N_RD-1:0]        rdReadyQ;

  for (genvar j = 0; j < N_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] rdSel;
    assign rdSel = bus.readSelect[j*ADDR_W +: ADDR_W];

    regfile_wr_merge #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .N_WR   (N_WR)
    ) u_merge (
      .readSel     (rdSel),
      .arrData     (mem[rdSel]),
      .arrReady    (readyBits[rdSel]),
      .writeEn     (wrEnRun),
      .writeSelect (bus.writeSelect),
      .writeData   (bus.writeData),
      .clearEn     (clrEnRun),
      .clearSelect (bus.clearSelect),
      .mergedData  (mergedData[j]),
      .mergedReady (mergedReady[j])
    );
  end

  // Reads sampled during the INIT sweep return zero data and a cleared ready bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdDataQ  <= '0;
      rdReadyQ <= '0;
    end else if (bus.en) begin
      for (int j = 0; j < N_RD; j++) begin
        rdDataQ[j*DATA_W +: DATA_W] <= isRun ? mergedData[j] : '0;
        rdReadyQ[j]                 <= isRun & mergedReady[j];
      end
    end
  end

  assign bus.readData  = rdDataQ;
  assign bus.readReady = rdReadyQ;

endmodule

// File: tb/tb_phys_reg_file_mp.sv
// Self-checking bench for phys_reg_file_mp: array-level reference model plus directed literal checks.
module tb_phys_reg_file_mp;
  import regfile_pkg::*;

  localparam int DW    = DATA_W_DEF;
  localparam int AW    = ADDR_W_DEF;
  localparam int NW    = N_WR_DEF;
  localparam int NR    = N_RD_DEF;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic reset;
  bit   checkOn;
  int   nTotal;
  int   nBad;

  phys_reg_file_mp_if bus ();

  phys_reg_file_mp dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nTotal++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-array semantics evaluated once per rising edge.
  logic [DW-1:0] mMem [DEPTH];
  logic          mRdy [DEPTH];
  int            initLeft;
  logic [DW-1:0] expData [NR];
  logic          expReady [NR];

  task automatic modelStep();
    logic [DW-1:0] newMem [DEPTH];
    logic          newRdy [DEPTH];
    bit            inInit;
    int            sel;
    inInit = (initLeft > 0);
    newMem = mMem;
    newRdy = mRdy;
    if (inInit) begin
      newMem[DEPTH - initLeft] = '0;
      newRdy[DEPTH - initLeft] = 1'b1;
      initLeft--;
    end else begin
      for (int i = 0; i < NW; i++)
        if (bus.writeEn[i]) begin
          sel = int'(bus.writeSelect[i*AW +: AW]);
          newMem[sel] = bus.writeData[i*DW +: DW];
          newRdy[sel] = 1'b1;
        end
      for (int i = 0; i < NW; i++)
        if (bus.clearEn[i]) newRdy[int'(bus.clearSelect[i*AW +: AW])] = 1'b0;
    end
    if (bus.en) begin
      for (int j = 0; j < NR; j++) begin
        sel = int'(bus.readSelect[j*AW +: AW]);
        if (inInit) begin
          expData[j]  = '0;
          expReady[j] = 1'b0;
        end else begin
`ifdef REGFILE_BYPASS_EN
          expData[j]  = newMem[sel];
          expReady[j] = newRdy[sel];
`else
          expData[j]  = mMem[sel];
          expReady[j] = mRdy[sel];
`endif
        end
      end
    end
    mMem = newMem;
    mRdy = newRdy;
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      mMem[k] = '0;
      mRdy[k] = 1'b0;
    end
    for (int j = 0; j < NR; j++) begin
      expData[j]  = '0;
      expReady[j] = 1'b0;
    end
    initLeft = DEPTH;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < NR; j++) begin
        expData[j]  = '0;
        expReady[j] = 1'b0;
      end
      initLeft = DEPTH;
    end else begin
      modelStep();
    end
  end

  always @(negedge clk) begin
    if (checkOn) begin
      check("initBusy", DW'(bus.initBusy), DW'(initLeft > 0));
      for (int j = 0; j < NR; j++) begin
        check($sformatf("readData[%0d]", j), bus.readData[j*DW +: DW], expData[j]);
        check($sformatf("readReady[%0d]", j), DW'(bus.readReady[j]), DW'(expReady[j]));
      end
    end
  end

  task automatic quiet();
    bus.writeEn     = '0;
    bus.writeSelect = '0;
    bus.writeData   = '0;
    bus.clearEn     = '0;
    bus.clearSelect = '0;
  endtask

  task automatic setRead(input int j, input int addr);
    bus.readSelect[j*AW +: AW] = AW'(addr);
  endtask

  task automatic setWrite(input int i, input int addr, input logic [DW-1:0] data);
    bus.writeEn[i]              = 1'b1;
    bus.writeSelect[i*AW +: AW] = AW'(addr);
    bus.writeData[i*DW +: DW]   = data;
  endtask

  // Counts rising edges until initBusy drops, bounded so a stuck DUT cannot hang the run.
  task automatic countBusy(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (bus.initBusy && n < 200);
  endtask

  int busyLen;

  initial begin
    nTotal  = 0;
    nBad    = 0;
    checkOn = 1'b0;
    reset   = 1'b1;
    bus.en  = 1'b0;
    bus.readSelect = '0;
    quiet();
    #3 reset = 1'b0;
    checkOn = 1'b1;

    // Reset state and INIT length
    @(negedge clk);
    check("rst_busy", DW'(bus.initBusy), DW'(1));
    check("rst_data0", bus.readData[0 +: DW], 32'h0);
    reset = 1'b1;
    countBusy(busyLen);
    check("init_len", DW'(busyLen), DW'(64));
    check("busy_low", DW'(bus.initBusy), DW'(0));

    // Entry 5 after INIT
    @(negedge clk);
    for (int j = 0; j < NR; j++) setRead(j, 5);
    bus.en = 1'b1;
    @(negedge clk);
    check("e5_data", bus.readData[0 +: DW], 32'h0);
    check("e5_ready", DW'(bus.readReady[0]), DW'(1));

    // Two ports write entry 9, highest index wins
    setWrite(0, 9, 32'hAAAA_0000);
    setWrite(2, 9, 32'h1234_5678);
    setRead(1, 9);
    @(negedge clk);
    quiet();
    @(negedge clk);
    check("prio_data", bus.readData[1*DW +: DW], 32'h1234_5678);
    check("prio_ready", DW'(bus.readReady[1]), DW'(1));

    // Same-cycle write and read of entry 3
    setWrite(0, 3, 32'hDEAD_BEEF);
    setRead(2, 3);
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    check("same_cyc_rd", bus.readData[2*DW +: DW], 32'hDEAD_BEEF);
`else
    check("same_cyc_rd", bus.readData[2*DW +: DW], 32'h0);
`endif
    quiet();

    // Clear and write of entry 7 in one cycle
    bus.clearEn[1]           = 1'b1;
    bus.clearSelect[AW +: AW] = AW'(7);
    setWrite(3, 7, 32'hCAFE_F00D);
    @(negedge clk);
    quiet();
    setRead(3, 7);
    @(negedge clk);
    check("clr_wr_data", bus.readData[3*DW +: DW], 32'hCAFE_F00D);
    check("clr_wr_ready", DW'(bus.readReady[3]), DW'(0));

    // Read-stage enable holds outputs
    setRead(0, 3);
    @(negedge clk);
    check("en_pre", bus.readData[0 +: DW], 32'hDEAD_BEEF);
    bus.en = 1'b0;
    setRead(0, 9);
    @(negedge clk);
    setRead(0, 7);
    @(negedge clk);
    check("en_hold", bus.readData[0 +: DW], 32'hDEAD_BEEF);
    bus.en = 1'b1;
    @(negedge clk);
    check("en_resume", bus.readData[0 +: DW], 32'hCAFE_F00D);

    // Randomised traffic against the model; narrow selects half the time to force collisions
    for (int c = 0; c < 3000; c++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      bus.en      = ($urandom_range(0, 3) != 0);
      bus.writeEn = NW'($urandom);
      bus.clearEn = ($urandom_range(0, 2) == 0) ? NW'($urandom) : '0;
      for (int i = 0; i < NW; i++) begin
        bus.writeSelect[i*AW +: AW] = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
        bus.clearSelect[i*AW +: AW] = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
        bus.writeData[i*DW +: DW]   = $urandom;
      end
      for (int j = 0; j < NR; j++)
        bus.readSelect[j*AW +: AW] = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      @(negedge clk);
    end

    // Reset mid-RUN after a write
    quiet();
    bus.en = 1'b1;
    setWrite(0, 20, 32'h0000_0055);
    @(negedge clk);
    quiet();
    setRead(0, 20);
    @(negedge clk);
    check("pre_rst_e20", bus.readData[0 +: DW], 32'h0000_0055);
    #2 reset = 1'b0;
    #1;
    check("run_rst_data", DW'(|bus.readData), DW'(0));
    check("run_rst_ready", DW'(|bus.readReady), DW'(0));
    check("run_rst_busy", DW'(bus.initBusy), DW'(1));
    @(negedge clk);
    reset = 1'b1;
    countBusy(busyLen);
    check("reinit_len", DW'(busyLen), DW'(64));
    @(negedge clk);
    @(negedge clk);
    check("post_rst_e20", bus.readData[0 +: DW], 32'h0);
    check("post_rst_rdy", DW'(bus.readReady[0]), DW'(1));

    // Reset mid-INIT, with writes and clears asserted during INIT
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NW; i++) setWrite(i, 11 + i, $urandom);
    bus.clearEn = '1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("init_rst_busy", DW'(bus.initBusy), DW'(1));
    @(negedge clk);
    reset = 1'b1;
    countBusy(busyLen);
    check("init_rst_len", DW'(busyLen), DW'(64));
    @(negedge clk);
    quiet();
    setRead(0, 12);
    @(negedge clk);
    @(negedge clk);
    check("init_ign_data", bus.readData[0 +: DW], 32'h0);
    check("init_ign_rdy", DW'(bus.readReady[0]), DW'(1));

    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule

// File: doc/phys_reg_file_mp.md
PHYS_REG_FILE_MP -- requirements
Module: phys_reg_file_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 6, meaning select width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter N_WR, default 4, meaning number of write ports.
REQ-004 SHALL have parameter N_RD, default 12, meaning number of read ports.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port en, input, 1, read-stage enable.
REQ-008 SHALL have port writeEn, input, N_WR, per-port write strobe.
REQ-009 SHALL have port writeSelect, input, N_WR*ADDR_W, per-port write address.
REQ-010 SHALL have port writeData, input, N_WR*DATA_W, per-port write data.
REQ-011 SHALL have port clearEn, input, N_WR, per-port ready-bit clear strobe (register allocation).
REQ-012 SHALL have port clearSelect, input, N_WR*ADDR_W, per-port clear address.
REQ-013 SHALL have port readSelect, input, N_RD*ADDR_W, per-port read address.
REQ-014 SHALL have port readData, output, N_RD*DATA_W, registered read data.
REQ-015 SHALL have port readReady, output, N_RD, registered ready bit of the addressed entry.
REQ-016 SHALL have port initBusy, output, 1, high while post-reset clear sequence runs.

Function
REQ-017 SHALL implement states INIT and RUN; reset forces INIT with counter 0.
REQ-018 SHALL in INIT write 0 to entry counter and set its ready bit each cycle, incrementing the counter; after entry DEPTH-1 SHALL enter RUN next cycle (initBusy high exactly DEPTH cycles after reset release).
REQ-019 SHALL ignore writeEn and clearEn while in INIT.
REQ-020 SHALL in RUN write writeData[i] to entry writeSelect[i] on every edge where writeEn[i]=1, and set that entry's ready bit.
REQ-021 SHALL, when several enabled write ports target one entry in one cycle, store the data of the highest-index port.
REQ-022 SHALL in RUN clear the ready bit of clearSelect[i] when clearEn[i]=1; a clear and a write to the same entry in one cycle SHALL leave ready=0 while storing the data.
REQ-023 SHALL sample readSelect[j] on each edge with en=1 and present readData[j]/readReady[j] on the following cycle (latency 1).
REQ-024 SHALL hold readData and readReady unchanged on edges with en=0; writes and clears proceed regardless of en.
REQ-025 SHALL return data 0 and ready 0 on all read ports for reads sampled during INIT.
REQ-026 SHALL treat all selects as unsigned modulo DEPTH; no out-of-range case exists.

Reset
REQ-027 SHALL on reset assertion immediately drive readData=0, readReady=0, initBusy=1, state INIT, counter 0, independent of clk.
REQ-028 SHALL restart the full INIT sequence if reset asserts mid-INIT or mid-RUN.

Configuration
REQ-029 SHALL, with REGFILE_BYPASS_EN defined, return for a read sampled in cycle t the data/ready as updated by writes and clears of cycle t (same priority rules).
REQ-030 SHALL, without REGFILE_BYPASS_EN, return the array contents as they were before cycle-t writes and clears.

Structure
REQ-031 SHALL take default DATA_W, ADDR_W, N_WR, N_RD values and the INIT/RUN state encoding from shared package regfile_pkg.
REQ-032 SHALL place write-port priority resolution and optional bypass in one sub-module regfile_wr_merge, instantiated once per read port.

Verification
REQ-033 SHALL check: reset release -> initBusy high 64 cycles, then low; read of entry 5 returns 0, ready 1.
REQ-034 SHALL check: writeEn=4'b0101, ports 0 and 2 write 0xAAAA0000 and 0x12345678 to entry 9 -> entry 9 holds 0x12345678.
REQ-035 SHALL check: write 0xDEADBEEF to entry 3 and read entry 3 same cycle -> next cycle 0xDEADBEEF with bypass, previous value without.
REQ-036 SHALL check: clearEn and writeEn on entry 7 same cycle -> data stored, readReady 0.
REQ-037 SHALL check: en=0 with changing readSelect -> readData unchanged; en=1 next edge -> updates.
REQ-038 SHALL check: reset asserted mid-RUN after writes -> outputs 0 immediately, INIT reruns, entry previously written reads 0.
